// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NUM_REQ byte requesters; a packet locks the grant until its last byte.
// Latency: req_valid to tx_req 1 cycle; req_ack pulses 1 cycle after tx_ready; 2 cycles of overhead per byte.
// Backpressure: a byte is held in SEND until tx_ready; requesters hold req_valid/req_data until their req_ack. Optional lock timeout: ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_req,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 locked,
  output logic                 lock_abort
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     gnt_q, gnt_d;
  logic [IDXW-1:0]     rr_q, rr_d;
  logic [IDXW-1:0]     rr_next;
  logic                last_q, last_d;
  logic                locked_q, locked_d;
  logic                tx_req_q, tx_req_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic                found;
  logic [IDXW-1:0]     win;
  logic [IDXW-1:0]     cand;
  int                  idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_q, abort_d;
  assign lock_abort = abort_q;
`else
  logic                unused_timeout;
  assign unused_timeout = (LOCK_TIMEOUT > 0);
  assign lock_abort     = 1'b0;
`endif

  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign req_ack  = req_ack_q;
  assign grant_id = 3'(gnt_q);
  assign locked   = locked_q;

  // Next-state and registered-output logic: arbitration in IDLE, byte hold in SEND, lock bookkeeping in ACK
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    last_d    = last_q;
    locked_d  = locked_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    req_ack_d = '0;
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    idx       = 0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = '0;
    abort_d   = 1'b0;
`endif
    rr_next   = (gnt_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_q + IDXW'(1);

    unique case (state_q)
      IDLE: begin
        if (locked_q) begin
          // Only the lock owner may continue its packet
          if (req_valid[gnt_q]) begin
            found = 1'b1;
            win   = gnt_q;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
            locked_d = 1'b0;
            rr_d     = rr_next;
            abort_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end else begin
          // First valid requester at or after rr_q, wrapping
          for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDXW'(idx);
            if (!found && req_valid[cand]) begin
              found = 1'b1;
              win   = cand;
            end
          end
        end
        if (found) begin
          tx_req_d  = 1'b1;
          tx_data_d = req_data[{win, 3'b000} +: 8];
          gnt_d     = win;
          last_d    = req_last[win];
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_req_d         = 1'b0;
          req_ack_d[gnt_q] = 1'b1;
          state_d          = ACK;
        end
      end
      ACK: begin
        // Requesters update valid/data during this cycle, so nothing is sampled here
        state_d = IDLE;
        if (last_q) begin
          locked_d = 1'b0;
          rr_d     = rr_next;
        end else begin
          locked_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; an in-flight byte is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      last_q    <= 1'b0;
      locked_q  <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      req_ack_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      last_q    <= last_d;
      locked_q  <= locked_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      req_ack_q <= req_ack_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner-case sequences, randomized packet traffic.
// Expected grants come from a packet-level round-robin model over per-requester byte lists.
// Serializer acceptance delay is randomized; spurious tx_ready pulses are injected outside SEND.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic           tx_req;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [2:0]     grant_id;
  logic           locked;
  logic           lock_abort;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant_id(grant_id), .locked(locked), .lock_abort(lock_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [2:0]  exp_g;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t tbl[8];

  // Random traffic: per-requester byte lists, {last, data}
  logic [8:0]  drv_mem[N][16];
  int          drv_cnt[N];
  int          drv_rd[N];
  logic [10:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Wait for a byte, check it, accept it; returns during the ack cycle
  task automatic serve(input logic [2:0] eg, input logic [7:0] ed, input string nm, output int lat);
    lat = 0;
    while (!tx_req && lat < 20) begin
      tick();
      lat++;
    end
    if (!tx_req) begin
      chk({nm, "_timeout"}, 32'(tx_req), 32'd1);
    end else begin
      chk({nm, "_grant"}, 32'(grant_id), 32'(eg));
      chk({nm, "_data"}, 32'(tx_data), 32'(ed));
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({nm, "_ack"}, 32'(req_ack), 32'(4'b0001 << eg));
    chk({nm, "_txreq_low"}, 32'(tx_req), 32'd0);
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (drv_rd[i] < drv_cnt[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = drv_mem[i][drv_rd[i]][7:0];
        req_last[i]        = drv_mem[i][drv_rd[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    int cyc;
    int dly;
    int ptr;
    int sel;
    int mrd[N];
    bit pend;
    bit seen;
    logic [3:0]  pend_mask;
    logic [10:0] e;
    logic [8:0]  b;

    tbl[0] = '{4'b0100, 32'h13411110, 3'd2, 8'h41};
    tbl[1] = '{4'b1111, 32'h23222120, 3'd3, 8'h23};
    tbl[2] = '{4'b0110, 32'h33323130, 3'd1, 8'h31};
    tbl[3] = '{4'b0011, 32'h43424140, 3'd0, 8'h40};
    tbl[4] = '{4'b1001, 32'h53525150, 3'd3, 8'h53};
    tbl[5] = '{4'b1010, 32'h63626160, 3'd1, 8'h61};
    tbl[6] = '{4'b0001, 32'h73727170, 3'd0, 8'h70};
    tbl[7] = '{4'b0010, 32'h83828180, 3'd1, 8'h81};

    do_reset();
    chk("rst_tx_req", 32'(tx_req), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_abort", 32'(lock_abort), 0);

    // Single-byte packets: round-robin pointer advances one past each winner
    for (int k = 0; k < 8; k++) begin
      req_valid = tbl[k].valid;
      req_data  = tbl[k].data;
      req_last  = '1;
      serve(tbl[k].exp_g, tbl[k].exp_d, $sformatf("vec%0d", k), lat);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 1);
      req_valid = '0;
      tick();
      chk($sformatf("vec%0d_ack_clear", k), 32'(req_ack), 0);
      chk($sformatf("vec%0d_unlocked", k), 32'(locked), 0);
    end

    // Packet lock: req0 sends "AB", req1 waits despite being valid
    req_valid = 4'b0011;
    req_data  = 32'h0000_5541;
    req_last  = 4'b0010;
    serve(3'd0, 8'h41, "lock_a", lat);
    req_data[7:0] = 8'h42;
    req_last[0]   = 1'b1;
    tick();
    chk("lock_held", 32'(locked), 1);
    serve(3'd0, 8'h42, "lock_b", lat);
    req_valid[0] = 1'b0;
    tick();
    chk("lock_released", 32'(locked), 0);
    serve(3'd1, 8'h55, "lock_next", lat);
    req_valid = '0;
    tick();

    // Hold stability: requester inputs change while the byte is in SEND
    req_valid = 4'b1000;
    req_data  = 32'hC300_0000;
    req_last  = 4'b1000;
    tick();
    chk("hold_txreq", 32'(tx_req), 1);
    chk("hold_grant", 32'(grant_id), 3);
    req_data  = '0;
    req_valid = '0;
    tick(); tick();
    chk("hold_data", 32'(tx_data), 32'hC3);
    chk("hold_txreq_stable", 32'(tx_req), 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("hold_ack", 32'(req_ack), 32'b1000);
    tick();
    chk("hold_ack_clear", 32'(req_ack), 0);

    // Reset while a first-of-packet byte is in flight, with tx_ready on the same edge
    req_valid = 4'b0100;
    req_data  = 32'h0077_0000;
    req_last  = 4'b0000;
    tick();
    chk("rstmid_txreq", 32'(tx_req), 1);
    reset = 1'b1; tx_ready = 1'b1;
    tick();
    reset = 1'b0; tx_ready = 1'b0; req_valid = '0;
    chk("rstmid_txreq_low", 32'(tx_req), 0);
    chk("rstmid_locked", 32'(locked), 0);
    chk("rstmid_no_ack", 32'(req_ack), 0);
    chk("rstmid_grant", 32'(grant_id), 0);
    tick();
    chk("rstmid_no_ack_late", 32'(req_ack), 0);

    // Lock owner goes idle mid-packet while req1 waits
    req_valid = 4'b0011;
    req_data  = 32'h0000_2110;
    req_last  = 4'b0010;
    serve(3'd0, 8'h10, "to_first", lat);
    req_valid[0] = 1'b0;
    tick();
    chk("to_locked", 32'(locked), 1);
`ifdef ARB_TIMEOUT_EN
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (lock_abort) seen = 1'b1;
      if (tx_req) cyc = 40;
    end
    chk("to_abort_seen", 32'(seen), 1);
    tick();
    chk("to_abort_unlocked", 32'(locked), 0);
    serve(3'd1, 8'h21, "to_grant1", lat);
`else
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (tx_req || lock_abort) seen = 1'b1;
    end
    chk("nto_no_grant", 32'(seen), 0);
    chk("nto_still_locked", 32'(locked), 1);
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h11;
    req_last[0]   = 1'b1;
    serve(3'd0, 8'h11, "nto_last", lat);
    req_valid[0] = 1'b0;
    serve(3'd1, 8'h21, "nto_grant1", lat);
`endif
    req_valid = '0;
    tick();

    // Randomized saturated traffic against a packet-level round-robin model
    for (int i = 0; i < N; i++) begin
      drv_cnt[i] = 0;
      drv_rd[i]  = 0;
      mrd[i]     = 0;
      for (int p = 0; p < int'($urandom_range(0, 4)); p++) begin
        int len;
        len = int'($urandom_range(1, 3));
        for (int j = 0; j < len; j++) begin
          drv_mem[i][drv_cnt[i]] = {(j == len - 1), 8'($urandom)};
          drv_cnt[i]++;
        end
      end
    end
    ptr = 0;
    forever begin
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && mrd[(ptr + k) % N] < drv_cnt[(ptr + k) % N]) sel = (ptr + k) % N;
      if (sel < 0) break;
      do begin
        b = drv_mem[sel][mrd[sel]];
        mrd[sel]++;
        exp_q.push_back({3'(sel), b[7:0]});
      end while (!b[8]);
      ptr = (sel + 1) % N;
    end

    do_reset();
    present();
    pend = 1'b0;
    pend_mask = '0;
    dly = 0;
    cyc = 0;
    while ((exp_q.size() > 0 || pend) && cyc < 4000) begin
      tick();
      cyc++;
      chk("rnd_ack", 32'(req_ack), pend ? 32'(pend_mask) : 32'd0);
      pend = 1'b0;
      for (int i = 0; i < N; i++)
        if (req_ack[i]) drv_rd[i]++;
      present();
      if (tx_req) begin
        if (dly == 0) begin
          tx_ready = 1'b1;
          if (exp_q.size() == 0) begin
            chk("rnd_extra_byte", 32'(tx_req), 0);
          end else begin
            e = exp_q.pop_front();
            chk("rnd_grant", 32'(grant_id), 32'(e[10:8]));
            chk("rnd_data", 32'(tx_data), 32'(e[7:0]));
            pend = 1'b1;
            pend_mask = 4'b0001 << e[10:8];
          end
        end else begin
          tx_ready = 1'b0;
          dly--;
        end
      end else begin
        tx_ready = ($urandom_range(0, 3) == 0);
        dly = int'($urandom_range(0, 3));
      end
    end
    tx_ready = 1'b0;
    chk("rnd_drained", 32'(exp_q.size()), 0);
    tick(); tick();
    chk("rnd_idle_txreq", 32'(tx_req), 0);
    chk("rnd_idle_unlocked", 32'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
